// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: RAM handshake state, data word and the
// wait-state controller's internal FSM state.
// No ports; imported by ram_wait_ctrl and ram_word_array.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Handshake state reported to the CPU-side memory port.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Internal sequencing state of ram_wait_ctrl.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2
  } rwstate_t;

endpackage

// File: rtl/ram_word_array.sv
// Single-port 2^ADDR_BITS x 32 word storage: synchronous write, read data
// presented from the indexed word while i_ren is high (the parent registers it).
// Ports: CLK, i_ren, i_wen, i_idx, i_wdata in; o_rdata out. Contents are not reset.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 CLK,
  input  logic                 i_ren,
  input  logic                 i_wen,
  input  logic [ADDR_BITS-1:0] i_idx,
  input  word_t                i_wdata,
  output word_t                o_rdata
);

  word_t r_mem [2**ADDR_BITS];

  always_ff @(posedge CLK) begin
    if (i_wen) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = i_ren ? r_mem[i_idx] : '0;

endmodule

// File: rtl/ram_wait_ctrl.sv
// Word-addressed RAM responder with LAT programmable wait states (LAT 1..15):
// BUSY for LAT cycles, then ACCESS for one cycle; one access in flight.
// Ports: CLK, nRST (async, active-low), ramREN, ramWEN, ramaddr, ramstore in;
// ramload, ramstate out. Optional macro RAM_ADDR_CHECK_EN flags misaligned or
// out-of-range addresses as ERROR; when undefined, addresses alias.
module ram_wait_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int ADDR_BITS = 12
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  rwstate_t             r_state, w_state_nxt;
  logic [3:0]           r_cnt, w_cnt_nxt;
  word_t                r_lat_addr;
  logic                 r_lat_wen;
  word_t                r_ramload;
  logic                 w_both, w_one, w_addr_err, w_valid, w_match;
  logic                 w_latch, w_mem_ren, w_mem_wen;
  word_t                w_mem_rdata;
  logic [ADDR_BITS-1:0] w_idx;

  assign w_both = ramREN & ramWEN;
  assign w_one  = ramREN ^ ramWEN;

`ifdef RAM_ADDR_CHECK_EN
  assign w_addr_err = (ramaddr[1:0] != 2'b00) || (ramaddr[31:ADDR_BITS+2] != '0);
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_valid = w_one & ~w_addr_err;
  // Full-address compare: any change while waiting restarts the access.
  assign w_match = w_valid && (ramWEN == r_lat_wen) && (ramaddr == r_lat_addr);
  assign w_idx   = ramaddr[ADDR_BITS+1:2];

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lat_addr <= '0;
      r_lat_wen  <= 1'b0;
      r_ramload  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_lat_addr <= ramaddr;
        r_lat_wen  <= ramWEN;
      end
      if (w_mem_ren) begin
        r_ramload <= w_mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_mem_ren   = 1'b0;
    w_mem_wen   = 1'b0;
    ramstate    = FREE;
    if ((r_state != IDLE) && w_match) begin
      if (r_state == WAIT) begin
        ramstate  = BUSY;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ACC;
          w_mem_ren   = ~r_lat_wen;
        end else begin
          w_state_nxt = WAIT;
        end
      end else begin
        // ACC: write data is taken on the edge that leaves this state.
        ramstate  = ACCESS;
        w_mem_wen = r_lat_wen;
      end
    end else begin
      // IDLE, or an aborted access: evaluate the current inputs afresh.
      if (w_both || (w_one && w_addr_err)) begin
        ramstate = ERROR;
      end else if (w_valid) begin
        ramstate  = BUSY;
        w_latch   = 1'b1;
        w_cnt_nxt = LAT_M1;
        if (LAT == 1) begin
          w_state_nxt = ACC;
          w_mem_ren   = ramREN;
        end else begin
          w_state_nxt = WAIT;
        end
      end
    end
  end

  ram_word_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .CLK     (CLK),
    .i_ren   (w_mem_ren),
    .i_wen   (w_mem_wen),
    .i_idx   (w_idx),
    .i_wdata (ramstore),
    .o_rdata (w_mem_rdata)
  );

  assign ramload = r_ramload;

endmodule
